// File: rtl/dac_fifo.sv
// dac_fifo: sample FIFO feeding the dac_c serial DAC controller.
// Read data is registered one cycle after rdreq. On underrun the last
// popped sample is re-presented (IDLE_CODE before any pop) so frame
// timing never stalls.
module dac_fifo #(
  parameter int unsigned    DW        = 16,
  parameter int unsigned    AW        = 4,
  parameter logic [DW-1:0]  IDLE_CODE = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  input  logic          rdreq,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          ovf,
  output logic          udf
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   level_q;
  logic          wr_acc;
  logic          rd_pop;

  // level never exceeds 2^AW, so its MSB alone marks the full state
  assign full  = level_q[AW];
  assign empty = (level_q == '0);
  assign level = level_q;

  // Accept/pop qualification uses the flags as they stand before the edge
  always_comb begin
    wr_acc = wr_en & ~full;
    rd_pop = rdreq & ~empty;
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointers, occupancy count, read data and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level_q  <= '0;
      dout     <= IDLE_CODE;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_pop) begin
        rptr <= rptr + AW'(1);
        dout <= mem[rptr];
      end
      case ({wr_acc, rd_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      dout_vld <= rdreq;
      ovf      <= wr_en & full;
      udf      <= rdreq & empty;
    end
  end

endmodule

// File: tb/tb_dac_fifo.sv
module tb_dac_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic        rdreq;
  logic [15:0] dout;
  logic        dout_vld;
  logic        ovf;
  logic        udf;

  int tests;
  int fails;

  dac_fifo #(.DW(16), .AW(4), .IDLE_CODE(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .level(level), .rdreq(rdreq),
    .dout(dout), .dout_vld(dout_vld), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance past one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // status vector: {empty, full, level, dout, dout_vld, ovf, udf}
  task automatic test_reset();
    logic [25:0] exp;
    rst_n = 1'b0; wr_en = 1'b0; rdreq = 1'b0; wr_data = '0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    exp = {1'b1, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if ({empty, full, level, dout, dout_vld, ovf, udf} !== exp) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", i,
                 {empty, full, level, dout, dout_vld, ovf, udf}, exp);
      end
    end
  endtask

  task automatic test_pass_through();
    logic [15:0] vals [3];
    vals[0] = 16'hC5F2; vals[1] = 16'h0001; vals[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = vals[i];
      tick();
    end
    wr_en = 1'b0;
    tests++;
    if (level !== 5'd3) begin
      fails++; $display("FAIL pass_level_full: got %0d expected 3", level);
    end
    for (int i = 0; i < 3; i++) begin
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      tests++;
      if (dout !== vals[i] || dout_vld !== 1'b1 || level !== 5'(2 - i)) begin
        fails++;
        $display("FAIL pass_read%0d: dout=%h vld=%b level=%0d expected dout=%h vld=1 level=%0d",
                 i, dout, dout_vld, level, vals[i], 2 - i);
      end
      tick();
      tests++;
      if (dout_vld !== 1'b0) begin
        fails++; $display("FAIL pass_vld_pulse%0d: vld=%b expected 0", i, dout_vld);
      end
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      tick();
      if (i == 14) begin
        tests++;
        if (full !== 1'b0 || level !== 5'd15) begin
          fails++; $display("FAIL not_full_15: full=%b level=%0d expected 0/15", full, level);
        end
      end
      if (i == 15) begin
        tests++;
        if (full !== 1'b1 || level !== 5'd16 || ovf !== 1'b0) begin
          fails++;
          $display("FAIL full_16: full=%b level=%0d ovf=%b expected 1/16/0", full, level, ovf);
        end
      end
      if (i == 16) begin
        tests++;
        if (ovf !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
          fails++;
          $display("FAIL ovf_pulse: ovf=%b level=%0d full=%b expected 1/16/1", ovf, level, full);
        end
      end
    end
    wr_en = 1'b0;
    tick();
    tests++;
    if (ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_not_sticky: ovf=%b expected 0", ovf);
    end
    for (int i = 0; i < 16; i++) begin
      rdreq = 1'b1;
      tick();
      tests++;
      if (dout !== 16'(i) || udf !== 1'b0 || dout_vld !== 1'b1) begin
        fails++;
        $display("FAIL drain%0d: dout=%h udf=%b vld=%b expected dout=%h udf=0 vld=1",
                 i, dout, udf, dout_vld, 16'(i));
      end
    end
    rdreq = 1'b0;
    tick();
    tests++;
    if (empty !== 1'b1 || level !== 5'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL drained_empty: empty=%b level=%0d full=%b expected 1/0/0", empty, level, full);
    end
  endtask

  task automatic test_underrun();
    wr_en = 1'b1; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0; rdreq = 1'b1;
    tick();
    tests++;
    if (dout !== 16'h1234 || udf !== 1'b0 || dout_vld !== 1'b1 || level !== 5'd0) begin
      fails++;
      $display("FAIL udf_first: dout=%h udf=%b vld=%b level=%0d expected 1234/0/1/0",
               dout, udf, dout_vld, level);
    end
    tick();
    rdreq = 1'b0;
    tests++;
    if (dout !== 16'h1234 || udf !== 1'b1 || dout_vld !== 1'b1 || level !== 5'd0) begin
      fails++;
      $display("FAIL udf_second: dout=%h udf=%b vld=%b level=%0d expected 1234/1/1/0",
               dout, udf, dout_vld, level);
    end
    tick();
    tests++;
    if (udf !== 1'b0 || dout_vld !== 1'b0) begin
      fails++; $display("FAIL udf_not_sticky: udf=%b vld=%b expected 0/0", udf, dout_vld);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 16'h5000 + 16'(i);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; wr_data = 16'h5005 + 16'(k); rdreq = 1'b1;
      tick();
      tests++;
      if (dout !== 16'h5000 + 16'(k) || level !== 5'd5 || dout_vld !== 1'b1 || udf !== 1'b0) begin
        fails++;
        $display("FAIL simul%0d: dout=%h level=%0d vld=%b udf=%b expected dout=%h level=5",
                 k, dout, level, dout_vld, udf, 16'h5000 + 16'(k));
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (dout !== 16'h5028 + 16'(i) || level !== 5'(4 - i)) begin
        fails++;
        $display("FAIL simul_drain%0d: dout=%h level=%0d expected dout=%h level=%0d",
                 i, dout, level, 16'h5028 + 16'(i), 4 - i);
      end
    end
    // write and read together while empty: read underruns, write lands
    wr_en = 1'b1; wr_data = 16'hABCD; rdreq = 1'b1;
    tick();
    wr_en = 1'b0; rdreq = 1'b0;
    tests++;
    if (udf !== 1'b1 || dout !== 16'h502C || level !== 5'd1 || empty !== 1'b0) begin
      fails++;
      $display("FAIL empty_wr_rd: udf=%b dout=%h level=%0d empty=%b expected 1/502c/1/0",
               udf, dout, level, empty);
    end
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    tests++;
    if (dout !== 16'hABCD || udf !== 1'b0 || level !== 5'd0) begin
      fails++;
      $display("FAIL empty_wr_rd_pop: dout=%h udf=%b level=%0d expected abcd/0/0", dout, udf, level);
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] exp;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 16'h7700 + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    tests++;
    if (level !== 5'd8) begin
      fails++; $display("FAIL pre_reset_level: got %0d expected 8", level);
    end
    rdreq = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tests++;
    if ({empty, full, level, dout, dout_vld, ovf, udf} !== exp) begin
      fails++;
      $display("FAIL reset_async: got %h expected %h",
               {empty, full, level, dout, dout_vld, ovf, udf}, exp);
    end
    tick();
    tick();
    tests++;
    if ({empty, full, level, dout, dout_vld, ovf, udf} !== exp) begin
      fails++;
      $display("FAIL reset_held: got %h expected %h",
               {empty, full, level, dout, dout_vld, ovf, udf}, exp);
    end
    #3;
    rdreq = 1'b0;
    rst_n = 1'b1;
    tick();
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    tests++;
    if (dout !== 16'h0000 || udf !== 1'b1 || dout_vld !== 1'b1 || level !== 5'd0) begin
      fails++;
      $display("FAIL post_reset_udf: dout=%h udf=%b vld=%b level=%0d expected 0000/1/1/0",
               dout, udf, dout_vld, level);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_pass_through();
    test_full_overflow();
    test_underrun();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_fifo.md
# dac_fifo

Sample buffer sitting directly upstream of the `dac_c` serial DAC controller. It accepts 16-bit DAC codes from a producer (wave generator or host register path), stores them in a synchronous FIFO, and answers `dac_c`'s `rdy` read request with `din`/`din_vld` exactly one cycle later. When the FIFO underruns, it re-presents the last sample, so the DAC frame timing never stalls.

## Interface
- `DW`, 16, sample width; matches `dac_c` `din`.
- `AW`, 4, address width; depth = 2^AW = 16 entries.
- `IDLE_CODE`, 16'h0000, value presented on `dout` after reset and on an underrun before any sample has been popped.

- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous active-low reset. In the top level it is driven from the `rst` module output, as `dac_c` is.
- `wr_data`  in  DW  sample from the producer.
- `wr_en`  in  1  write strobe, one sample per cycle.
- `full`  out  1  FIFO holds 2^AW entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  AW+1  current entry count, 0..2^AW.
- `rdreq`  in  1  read request; connected to `dac_c` `rdy`.
- `dout`  out  DW  sample to `dac_c` `din`.
- `dout_vld`  out  1  connected to `dac_c` `din_vld`.
- `ovf`  out  1  one-cycle pulse: write dropped because FIFO full.
- `udf`  out  1  one-cycle pulse: read served while FIFO empty.

## Operation
- Storage is a 2^AW x DW register array with `wptr` and `rptr` of AW bits each. Both pointers wrap modulo 2^AW.
- `level` is a separate AW+1-bit counter. `full` = (`level` == 2^AW). `empty` = (`level` == 0). Both are decoded from registered `level`.
- Write accepted = `wr_en` & !`full`, where `full` is sampled before the edge:
  - An accepted write stores `wr_data` at `wptr` and increments `wptr`.
  - `wr_en` & `full` drops the sample and pulses `ovf`. The write is dropped even if `rdreq` pops in the same cycle.
- Read on `rdreq` high at edge N. Results are registered and visible in the cycle after edge N:
  - If !`empty`: `dout` <= mem[`rptr`], `rptr` increments, and the last-sample register is updated.
  - If `empty`: `dout` holds its previous value (`IDLE_CODE` if nothing has been popped yet) and `udf` pulses.
  - In both cases `dout_vld` <= 1 for exactly one cycle.
- `rdreq` held high for consecutive cycles gives one pop per cycle, with `dout_vld` high on each following cycle.
- Simultaneous accepted write and non-empty read: `level` is unchanged and both pointers advance.
- Simultaneous write and read while empty: the read underruns (there is no write-through bypass). The write is stored and `level` becomes 1.
- `level` update: +1 for an accepted write only, -1 for a non-empty read only, otherwise unchanged.
- Reset (asynchronous, at any time including mid-burst):
  - `wptr`, `rptr`, `level` = 0; `empty` = 1; `full` = 0.
  - `dout` = `IDLE_CODE`; `dout_vld`, `ovf`, `udf` = 0.
  - FIFO contents are discarded. Memory array contents need no reset.

## Timing
- Read latency: `rdreq` high in cycle N gives `dout`/`dout_vld` valid in cycle N+1. This matches the one-cycle registered `din_vld` <= `rdy` that `dac_c` expects.
- Write-to-readable: a write accepted at edge k makes `empty` = 0 from cycle k+1. A `rdreq` in cycle k+1 returns that sample in cycle k+2.
- `full`/`empty`/`level` update on the same edge as the pointer change. No lookahead flags.
- `ovf` and `udf` are high for exactly the cycle after the offending edge, and are never sticky.
- All outputs are registered. No combinational path exists from `rdreq` or `wr_en` to any output.

## Test plan
- Reset then idle: after `rst_n` release, `empty` = 1, `level` = 0, `dout` = 16'h0000, `dout_vld` = 0, `ovf` = `udf` = 0 for 10 cycles.
- Ordered pass-through:
  - Stimulus: write 16'hC5F2, 16'h0001, 16'hFFFF in consecutive cycles, then pulse `rdreq` three times, 2 cycles apart.
  - Required: `dout` = C5F2, 0001, FFFF, each with a 1-cycle `dout_vld` in the cycle after its `rdreq`; `level` steps 3 -> 0.
- Full / overflow:
  - Stimulus: write 17 samples 0..16 back-to-back.
  - Required: `full` = 1 after the 16th write, `ovf` pulses once for sample 16, `level` = 16; draining yields 0..15.
- Underrun hold:
  - Stimulus: write 16'h1234, read twice.
  - Required: first read `dout` = 1234 with `udf` = 0; second read `dout` = 1234, `dout_vld` = 1, `udf` = 1; `level` stays 0.
- Simultaneous write + read with `level` = 5: `level` stays 5; the oldest entry appears on `dout`; pointer wrap is exercised by repeating the pattern 40 times with no corruption.
- Reset mid-operation:
  - Stimulus: with `level` = 8 and `rdreq` pulsing, assert `rst_n` low asynchronously (mid-cycle).
  - Required: all outputs return to reset values immediately; the next read after release underruns with `dout` = `IDLE_CODE`.
